// File: rtl/dbus_sram_responder_pkg.sv
// dbus_sram_responder_pkg
//   Data-bus request/response types shared with the core, plus the local constants and
//   state type used by the SRAM responder.
//   Contents:
//     strobe_t       8-bit byte-lane write strobe
//     dbus_req_t     valid, addr(64), size, strobe(8), data(64)
//     dbus_resp_t    addr_ok, data_ok, data(64)
//     DRESP_LAT_W    width of the configured wait-state count (LATENCY 0..15)
//     dresp_state_t  responder FSM states
//     lfsr8_next()   one step of the x^8+x^6+x^5+x^4+1 Fibonacci LFSR

package dbus_sram_responder_pkg;

    typedef logic [7:0] strobe_t;
    typedef logic [2:0] msize_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        msize_t      size;
        strobe_t     strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;

    localparam int unsigned DRESP_LAT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } dresp_state_t;

    // Shift left, feedback from taps 8,6,5,4 (bits 7,5,4,3) into bit 0.
    function automatic logic [7:0] lfsr8_next(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

endpackage

// File: rtl/dbus_sram_responder_if.sv
// dbus_sram_responder_if
//   Bundles the core data-bus handshake between the memory stage (master) and the SRAM
//   responder (slave).
//   Signals:
//     dreq   request from the core
//     dresp  response to the core
//     busy   responder has a transaction outstanding
//   Modports:
//     master  drives dreq, observes dresp and busy
//     slave   observes dreq, drives dresp and busy

interface dbus_sram_responder_if;
    import dbus_sram_responder_pkg::*;

    dbus_req_t  dreq;
    dbus_resp_t dresp;
    logic       busy;

    modport master (
        output dreq,
        input  dresp,
        input  busy
    );

    modport slave (
        input  dreq,
        output dresp,
        output busy
    );

endinterface

// File: rtl/dbus_sram_responder_sram.sv
// sram_word_array
//   Depth x 64-bit storage with one synchronous read port and one byte-strobed
//   synchronous write port. No reset; contents power up undefined.
//   Ports:
//     clk_i    clock
//     raddr_i  read word index; data appears on rdata_o after the next rising edge
//     rdata_o  registered read data (old contents when read and write collide)
//     we_i     write enable
//     waddr_i  write word index
//     wstrb_i  byte-lane enables for the write
//     wdata_i  write data

module sram_word_array #(
    parameter int unsigned Depth = 4096,
    parameter int unsigned AddrW = $clog2(Depth)
) (
    input  logic             clk_i,
    input  logic [AddrW-1:0] raddr_i,
    output logic [63:0]      rdata_o,
    input  logic             we_i,
    input  logic [AddrW-1:0] waddr_i,
    input  logic [7:0]       wstrb_i,
    input  logic [63:0]      wdata_i
);

    logic [63:0] mem [Depth];
    logic [63:0] rdata_q;

    always_ff @(posedge clk_i) begin
        rdata_q <= mem[raddr_i];
        if (we_i) begin
            for (int b = 0; b < 8; b++) begin
                if (wstrb_i[b]) begin
                    mem[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dbus_sram_responder.sv
// dbus_sram_responder
//   Responder end of the core data bus. Accepts one request at a time, waits a fixed
//   number of cycles, then returns data_ok with the full stored 64-bit word (read before
//   the write) and commits any strobed bytes in the same cycle. Addresses outside
//   [BASE, BASE + 8*DEPTH) read as zero and drop their writes.
//   Parameters:
//     DEPTH    number of 64-bit words (power of two)
//     BASE     byte address of word 0
//     LATENCY  wait-state cycles between accept and response, 0..15
//   Ports:
//     clk    clock, rising edge
//     reset  asynchronous active-low reset
//     bus    slave side of dbus_sram_responder_if (dreq in; dresp, busy out)
//   Build option:
//     DBUS_RESP_RANDLAT_EN  adds 0..3 extra wait cycles per request from an 8-bit LFSR
//                           (seed 8'hA5, stepped once per accepted request).

module dbus_sram_responder
    import dbus_sram_responder_pkg::*;
#(
    parameter int unsigned DEPTH   = 4096,
    parameter logic [63:0] BASE    = 64'h8000_0000,
    parameter int unsigned LATENCY = 1
) (
    input logic                  clk,
    input logic                  reset,
    dbus_sram_responder_if.slave bus
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    // One spare bit so LATENCY plus the random extra (up to 15 + 3) fits.
    localparam int unsigned CNT_W = DRESP_LAT_W + 1;
    localparam logic [63:0] SPAN  = 64'(DEPTH) << 3;

    dresp_state_t     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] wait_cnt;

    logic [IDX_W-1:0] idx_q;
    strobe_t          strb_q;
    logic [63:0]      wdata_q;
    logic             inr_q;

    logic [63:0]      offset;
    logic             req_inr;
    logic [IDX_W-1:0] req_idx;
    logic [IDX_W-1:0] rd_idx;
    logic             accept;
    logic             sram_we;
    logic [63:0]      rdata;
    dbus_resp_t       resp;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    assign offset  = bus.dreq.addr - BASE;
    assign req_inr = (bus.dreq.addr >= BASE) && (offset < SPAN);
    assign req_idx = offset[IDX_W+2:3];
    assign accept  = (state_q == IDLE) && bus.dreq.valid;

    // ------------------------------------------------------------------
    // Wait-state count
    // ------------------------------------------------------------------
`ifdef DBUS_RESP_RANDLAT_EN
    logic [7:0] lfsr_q;

    assign wait_cnt = CNT_W'(LATENCY) + CNT_W'(lfsr_q[1:0]);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr_q <= 8'hA5;
        end else if (accept) begin
            lfsr_q <= lfsr8_next(lfsr_q);
        end
    end
`else
    assign wait_cnt = CNT_W'(LATENCY);
`endif

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    cnt_d   = wait_cnt;
                    state_d = (wait_cnt != '0) ? WAIT : RESP;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            strb_q  <= '0;
            wdata_q <= '0;
            inr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                idx_q   <= req_idx;
                strb_q  <= bus.dreq.strobe;
                wdata_q <= bus.dreq.data;
                inr_q   <= req_inr;
            end
        end
    end

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    // The read is registered, so the index must be presented one cycle ahead of RESP.
    // In IDLE that is the live request (covers LATENCY=0); afterwards the latched index
    // keeps refreshing rdata until RESP, which then sees the word before its own write.
    assign rd_idx  = (state_q == IDLE) ? req_idx : idx_q;
    assign sram_we = (state_q == RESP) && inr_q && (strb_q != '0);

    sram_word_array #(
        .Depth (DEPTH)
    ) u_sram (
        .clk_i   (clk),
        .raddr_i (rd_idx),
        .rdata_o (rdata),
        .we_i    (sram_we),
        .waddr_i (idx_q),
        .wstrb_i (strb_q),
        .wdata_i (wdata_q)
    );

    // ------------------------------------------------------------------
    // Response
    // ------------------------------------------------------------------
    always_comb begin
        resp = '0;
        // Gated by reset so every output reads 0 while reset is held.
        resp.addr_ok = accept && reset;
        resp.data_ok = (state_q == RESP);
        resp.data    = ((state_q == RESP) && inr_q) ? rdata : 64'h0;
    end

    assign bus.dresp = resp;
    assign bus.busy  = (state_q != IDLE);

    // size and the sub-word/high offset bits do not affect the datapath.
    logic unused_bits;
    assign unused_bits = ^{bus.dreq.size, offset[2:0], offset[63:IDX_W+3]};

endmodule

// File: tb/tb_dbus_sram_responder.sv
// Bench for dbus_sram_responder: three instances (LATENCY 1, 0, 8) with a per-cycle
// transaction-level model plus directed literal expectations.

module tb_dbus_sram_responder;
    import dbus_sram_responder_pkg::*;

    localparam int unsigned DEPTH = 256;
    localparam logic [63:0] BASE  = 64'h8000_0000;
    localparam int unsigned L0 = 1;
    localparam int unsigned L1 = 0;
    localparam int unsigned L2 = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dbus_req_t  req_a  [3];
    dbus_resp_t resp_a [3];
    logic       busy_a [3];

    dbus_sram_responder_if bus0 ();
    dbus_sram_responder_if bus1 ();
    dbus_sram_responder_if bus2 ();

    assign bus0.dreq = req_a[0];
    assign bus1.dreq = req_a[1];
    assign bus2.dreq = req_a[2];
    assign resp_a[0] = bus0.dresp;
    assign resp_a[1] = bus1.dresp;
    assign resp_a[2] = bus2.dresp;
    assign busy_a[0] = bus0.busy;
    assign busy_a[1] = bus1.busy;
    assign busy_a[2] = bus2.busy;

    dbus_sram_responder #(.DEPTH(DEPTH), .BASE(BASE), .LATENCY(L0)) u0 (
        .clk(clk), .reset(rst_n), .bus(bus0));
    dbus_sram_responder #(.DEPTH(DEPTH), .BASE(BASE), .LATENCY(L1)) u1 (
        .clk(clk), .reset(rst_n), .bus(bus1));
    dbus_sram_responder #(.DEPTH(DEPTH), .BASE(BASE), .LATENCY(L2)) u2 (
        .clk(clk), .reset(rst_n), .bus(bus2));

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic int lat_of(input int i);
        if (i == 0) return int'(L0);
        if (i == 1) return int'(L1);
        return int'(L2);
    endfunction

    function automatic bit in_range(input logic [63:0] a);
        return (a >= BASE) && (a < BASE + 64'(DEPTH) * 64'd8);
    endfunction

    function automatic longint key_of(input int i, input logic [63:0] a);
        return (longint'(i) << 32) | longint'((a - BASE) >> 3);
    endfunction

    // Reference LFSR: x^8+x^6+x^5+x^4+1, shift toward MSB.
    function automatic logic [7:0] ref_lfsr(input logic [7:0] s);
        logic fb;
        fb = s[7] ^ s[5] ^ s[4] ^ s[3];
        return {s[6:0], fb};
    endfunction

    // ------------------------------------------------------------------
    // Model: one outstanding transaction per instance, response due W+1 cycles after
    // accept; memory is a sparse map of words whose full contents are known.
    // ------------------------------------------------------------------
    longint      cyc = 0;
    bit          m_busy  [3];
    longint      m_due   [3];
    logic [63:0] m_addr  [3];
    logic [7:0]  m_strb  [3];
    logic [63:0] m_wdata [3];
    logic [7:0]  m_lfsr  [3];
    logic [63:0] mem_m [longint];

    always @(negedge clk) begin
        cyc++;
        for (int i = 0; i < 3; i++) begin
            logic        e_aok, e_dok, e_busy, known;
            logic [63:0] e_data, wv;
            longint      k;
            int          w;
            e_aok = 1'b0; e_dok = 1'b0; e_busy = 1'b0; e_data = '0; known = 1'b1;
            if (!rst_n) begin
                m_busy[i] = 1'b0;
                m_lfsr[i] = 8'hA5;
            end else if (!m_busy[i]) begin
                e_aok = req_a[i].valid;
            end else begin
                e_busy = 1'b1;
                if (cyc == m_due[i]) begin
                    e_dok = 1'b1;
                    if (in_range(m_addr[i])) begin
                        k = key_of(i, m_addr[i]);
                        if (mem_m.exists(k)) e_data = mem_m[k];
                        else known = 1'b0;
                    end
                end
            end
            check($sformatf("u%0d addr_ok @%0d", i, cyc), resp_a[i].addr_ok, e_aok);
            check($sformatf("u%0d data_ok @%0d", i, cyc), resp_a[i].data_ok, e_dok);
            check($sformatf("u%0d busy @%0d", i, cyc), busy_a[i], e_busy);
            if (known) check($sformatf("u%0d data @%0d", i, cyc), resp_a[i].data, e_data);

            if (rst_n) begin
                if (!m_busy[i] && req_a[i].valid) begin
                    w = lat_of(i);
`ifdef DBUS_RESP_RANDLAT_EN
                    w += int'(m_lfsr[i][1:0]);
                    m_lfsr[i] = ref_lfsr(m_lfsr[i]);
`endif
                    m_addr[i]  = req_a[i].addr;
                    m_strb[i]  = req_a[i].strobe;
                    m_wdata[i] = req_a[i].data;
                    m_due[i]   = cyc + longint'(w) + 1;
                    m_busy[i]  = 1'b1;
                end else if (m_busy[i] && cyc == m_due[i]) begin
                    if (in_range(m_addr[i]) && m_strb[i] != 8'h00) begin
                        k = key_of(i, m_addr[i]);
                        if (mem_m.exists(k) || m_strb[i] == 8'hFF) begin
                            wv = mem_m.exists(k) ? mem_m[k] : 64'h0;
                            for (int b = 0; b < 8; b++)
                                if (m_strb[i][b]) wv[8*b +: 8] = m_wdata[i][8*b +: 8];
                            mem_m[k] = wv;
                        end
                    end
                    m_busy[i] = 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    // One full transaction; request fields are scrambled right after accept.
    task automatic xact(input int i, input logic [63:0] a, input logic [7:0] s,
                        input logic [63:0] d, output logic [63:0] rd, output int lat);
        bit got;
        rd  = '0;
        lat = -1;
        req_a[i].addr   = a;
        req_a[i].strobe = s;
        req_a[i].data   = d;
        req_a[i].size   = 3'd3;
        req_a[i].valid  = 1'b1;
        got = 1'b0;
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge clk);
            got = resp_a[i].addr_ok;
        end
        check($sformatf("u%0d accept seen", i), got, 1);
        @(posedge clk);
        #1;
        req_a[i].valid  = 1'b0;
        req_a[i].addr   = ~a;
        req_a[i].data   = ~d;
        req_a[i].strobe = ~s;
        if (got) begin
            got = 1'b0;
            for (int n = 1; n <= 40 && !got; n++) begin
                @(negedge clk);
                if (resp_a[i].data_ok) begin
                    got = 1'b1;
                    rd  = resp_a[i].data;
                    lat = n;
                end
            end
            check($sformatf("u%0d data_ok seen", i), got, 1);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [63:0] rd;
        int          lat;
        logic [5:0]  ap, dp;
        bit          got;
        int          hist [4];
        logic [7:0]  rl;

        for (int i = 0; i < 3; i++) req_a[i] = '0;

        // Reset state
        #2;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("u%0d reset addr_ok", i), resp_a[i].addr_ok, 0);
            check($sformatf("u%0d reset data_ok", i), resp_a[i].data_ok, 0);
            check($sformatf("u%0d reset data", i), resp_a[i].data, 0);
            check($sformatf("u%0d reset busy", i), busy_a[i], 0);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Read after write, LATENCY=1
        xact(0, BASE + 64'd8, 8'hFF, 64'h1122_3344_5566_7788, rd, lat);
`ifndef DBUS_RESP_RANDLAT_EN
        check("raw write latency", lat, 2);
`endif
        xact(0, BASE + 64'd8, 8'h00, 64'h0, rd, lat);
`ifndef DBUS_RESP_RANDLAT_EN
        check("raw read latency", lat, 2);
`endif
        check("raw read data", rd, 64'h1122_3344_5566_7788);

        // Partial strobe; the strobed write's own response shows the pre-write word
        xact(0, BASE + 64'd16, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, rd, lat);
        xact(0, BASE + 64'd16, 8'h0F, 64'h0, rd, lat);
        check("partial write old data", rd, 64'hFFFF_FFFF_FFFF_FFFF);
        xact(0, BASE + 64'd16, 8'h00, 64'h0, rd, lat);
        check("partial read data", rd, 64'hFFFF_FFFF_0000_0000);

        // Out of range, above and below
        xact(0, BASE, 8'hFF, 64'hA5A5_0000_DEAD_BEEF, rd, lat);
        xact(0, BASE + 64'(DEPTH) * 64'd8, 8'hFF, 64'h0123_4567_89AB_CDEF, rd, lat);
        check("oor write data", rd, 64'h0);
`ifndef DBUS_RESP_RANDLAT_EN
        check("oor write latency", lat, 2);
`endif
        xact(0, BASE + 64'(DEPTH) * 64'd8, 8'h00, 64'h0, rd, lat);
        check("oor read data", rd, 64'h0);
        xact(0, BASE - 64'd8, 8'hFF, 64'h5555_6666_7777_8888, rd, lat);
        check("below base data", rd, 64'h0);
        xact(0, BASE + 64'(DEPTH - 1) * 64'd8, 8'h00, 64'h0, rd, lat);
        xact(0, BASE, 8'h00, 64'h0, rd, lat);
        check("word 0 unmodified", rd, 64'hA5A5_0000_DEAD_BEEF);

        // LATENCY=0 back-to-back with valid held across three reads
        xact(1, BASE + 64'd24, 8'hFF, 64'h0BAD_CAFE_1234_5678, rd, lat);
`ifndef DBUS_RESP_RANDLAT_EN
        check("lat0 write latency", lat, 1);
`endif
        req_a[1].addr   = BASE + 64'd24;
        req_a[1].strobe = 8'h00;
        req_a[1].data   = 64'h0;
        req_a[1].valid  = 1'b1;
        got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            got = resp_a[1].addr_ok;
        end
        check("b2b first accept", got, 1);
        ap = '0;
        dp = '0;
        ap[0] = resp_a[1].addr_ok;
        dp[0] = resp_a[1].data_ok;
        for (int t = 1; t < 6; t++) begin
            @(posedge clk);
            #1;
            if (t == 5) req_a[1].valid = 1'b0;
            @(negedge clk);
            ap[t] = resp_a[1].addr_ok;
            dp[t] = resp_a[1].data_ok;
            if (resp_a[1].data_ok) check($sformatf("b2b data t%0d", t), resp_a[1].data,
                                         64'h0BAD_CAFE_1234_5678);
        end
`ifndef DBUS_RESP_RANDLAT_EN
        check("b2b accept cycles", ap, 6'b010101);
        check("b2b data_ok cycles", dp, 6'b101010);
`endif
        @(posedge clk);
        #1;

        // Reset mid-WAIT, LATENCY=8
        xact(2, BASE + 64'd32, 8'hFF, 64'hCAFE_F00D_0000_1111, rd, lat);
        req_a[2].addr   = BASE + 64'd32;
        req_a[2].strobe = 8'hFF;
        req_a[2].data   = 64'h9999_8888_7777_6666;
        req_a[2].valid  = 1'b1;
        got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            got = resp_a[2].addr_ok;
        end
        check("rst accept", got, 1);
        @(posedge clk);
        #1;
        req_a[2].valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst busy before", busy_a[2], 1);
        rst_n = 1'b0;
        #1;
        check("rst addr_ok", resp_a[2].addr_ok, 0);
        check("rst data_ok", resp_a[2].data_ok, 0);
        check("rst data", resp_a[2].data, 0);
        check("rst busy", busy_a[2], 0);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        xact(2, BASE + 64'd32, 8'h00, 64'h0, rd, lat);
        check("rst old data kept", rd, 64'hCAFE_F00D_0000_1111);
`ifndef DBUS_RESP_RANDLAT_EN
        check("lat8 read latency", lat, 9);
`endif

`ifdef DBUS_RESP_RANDLAT_EN
        // Random extra latency against a reference LFSR seeded 8'hA5
        do_reset();
        rl = 8'hA5;
        xact(0, BASE + 64'd40, 8'hFF, 64'h7777_0000_7777_0000, rd, lat);
        check("rand write latency", lat, 2 + int'(rl[1:0]));
        rl = ref_lfsr(rl);
        for (int h = 0; h < 4; h++) hist[h] = 0;
        for (int r = 0; r < 256; r++) begin
            xact(0, BASE + 64'd40, 8'h00, 64'h0, rd, lat);
            check($sformatf("rand latency %0d", r), lat, 2 + int'(rl[1:0]));
            if (lat >= 2 && lat <= 5) hist[lat-2]++;
            else check($sformatf("rand latency range %0d", r), lat, 2);
            rl = ref_lfsr(rl);
        end
        for (int h = 0; h < 4; h++) check($sformatf("rand latency %0d seen", h + 2),
                                          hist[h] > 0, 1);
`endif

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/dbus_sram_responder.md
# dbus_sram_responder

Responder end of the core's data-bus (`dbus_req_t` / `dbus_resp_t`) handshake: accepts one request at a time from the core's memory stage and services it from a local 64-bit-wide, byte-strobed SRAM. After a configurable number of wait states it returns `data_ok` with read data, or commits write data. It sits between the core's `dreq`/`dresp` ports and on-chip storage, and serves as the simulation and bring-up data memory behind the pipeline.

## Interface
Parameters:
- `DEPTH`, 4096: number of 64-bit words; power of two.
- `BASE`, 64'h8000_0000: byte address of word 0.
- `LATENCY`, 1: fixed wait-state cycles between accept and response, range 0..15.

Ports:
- `clk`  in  1  clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `dreq`  in  `dbus_req_t`  request: `valid`, `addr` (64), `size`, `strobe` (8), `data` (64).
- `dresp`  out  `dbus_resp_t`  response: `addr_ok`, `data_ok`, `data` (64).
- `busy`  out  1  high while a transaction is outstanding (WAIT or RESP).

## Operation
- Three-state FSM: IDLE, WAIT, RESP.
- IDLE: when `dreq.valid`=1, accept the request.
  - Drive `addr_ok`=1 combinationally in that cycle.
  - Latch `addr`, `strobe`, `data`.
  - Load the wait counter with the total wait count.
  - Go to WAIT if the wait count is nonzero, otherwise to RESP.
- WAIT: decrement the counter each cycle. Go to RESP in the cycle the counter reaches 1.
- RESP (one cycle):
  - `data_ok`=1.
  - `dresp.data` = full stored 64-bit word at the latched index, read before the write. Lanes are not shifted; the core extracts bytes.
  - If latched `strobe`≠0, write byte lane i where `strobe[i]`=1 at this clock edge.
  - Return to IDLE.
- Index = (`addr` − `BASE`)[3+log2(DEPTH)−1:3]. `addr[2:0]` is ignored; `strobe` is authoritative. `size` is not used for the datapath.
- Out of range (`addr` < `BASE` or `addr` ≥ `BASE`+8·DEPTH): read data = 64'h0 and the write is dropped. `data_ok` timing is unchanged.
- Request fields are used only as latched. If `dreq` changes or `valid` drops after accept, the transaction still completes, including the write.
- Only one transaction is outstanding at a time. `addr_ok`=0 in WAIT and RESP, regardless of `valid`.

## Timing
- Reset values: state=IDLE, `dresp.addr_ok`=0, `data_ok`=0, `data`=0, `busy`=0, counter=0.
- SRAM contents are not reset.
- Reset asserted mid-transaction: the FSM returns to IDLE immediately and any pending write is discarded.
- Accept-to-`data_ok` latency = W+1 cycles, where W = LATENCY plus the random extra, if enabled.
  - LATENCY=0: `data_ok` arrives the cycle after accept.
- `dresp.data` is valid only while `data_ok`=1; it is 0 in all other cycles.
- Back-to-back requests: the cycle after RESP is IDLE, so a held or new `valid` is accepted there. Maximum throughput is one transaction per W+2 cycles.
- `busy`=1 from the cycle after accept through the RESP cycle.

## Configuration
- `DBUS_RESP_RANDLAT_EN` defined:
  - 8-bit Fibonacci LFSR, taps x^8+x^6+x^5+x^4+1, reset seed 8'hA5.
  - The LFSR steps once per accepted request.
  - `lfsr[1:0]` sampled at accept adds 0..3 extra wait cycles, so W = LATENCY + `lfsr[1:0]`.
- Not defined: W = LATENCY exactly; no LFSR logic is built.

## Structure
- Shared package (`common`): `dbus_req_t`, `dbus_resp_t`, `strobe_t` (existing).
- New package entries: `DRESP_LAT_W`=4 and an enum `dresp_state_t` {IDLE, WAIT, RESP}.
- One sub-module: `sram_word_array`. It holds DEPTH×64 storage, has one read port and one byte-strobed write port, is synchronous, and has no reset.

## Test plan
- Read after write, LATENCY=1:
  - Stimulus: write `addr`=BASE+8, `strobe`=8'hFF, `data`=64'h1122_3344_5566_7788, then read the same address.
  - Required: `addr_ok` on each accept cycle; `data_ok` 2 cycles after each accept; read returns 64'h1122_3344_5566_7788.
- Partial strobe:
  - Stimulus: write 64'hFFFF_FFFF_FFFF_FFFF with strobe 8'hFF, then write 64'h0 with strobe 8'h0F, then read.
  - Required: read returns 64'hFFFF_FFFF_0000_0000.
- Out of range:
  - Stimulus: write, then read, at `addr`=BASE+8·DEPTH.
  - Required: `data_ok` with standard timing; read data 64'h0; word 0 unmodified.
- LATENCY=0 back-to-back, with `valid` held high across 3 reads:
  - Required: accepts at cycles 0, 2, 4; `data_ok` at cycles 1, 3, 5; `addr_ok`=0 in the RESP cycles.
- Reset mid-WAIT, LATENCY=8:
  - Stimulus: assert `reset` 3 cycles after accepting a write.
  - Required: all outputs 0 immediately; a later read shows the old data.
- `DBUS_RESP_RANDLAT_EN`, LATENCY=1:
  - Stimulus: 256 reads.
  - Required: every latency is in 2..5, each of the four values occurs, and the sequence matches a reference LFSR seeded with 8'hA5.
